// File: rtl/scoreboard_if.sv
// Playfield <-> scoreboard signal bundle: round-win levels in,
// scores, digit patterns and round/match control out.
interface scoreboard_if;
    logic       win_l;
    logic       win_r;
    logic [2:0] score_l;
    logic [2:0] score_r;
    logic [6:0] hex_l;
    logic [6:0] hex_r;
    logic       round_reset;
    logic       match_over;

    modport master (
        output win_l, win_r,
        input  score_l, score_r, hex_l, hex_r,
        input  round_reset, match_over
    );

    modport slave (
        input  win_l, win_r,
        output score_l, score_r, hex_l, hex_r,
        output round_reset, match_over
    );
endinterface

// File: rtl/scoreboard.sv
// Tug-of-war round scoreboard: edge-counted wins, hold/restart FSM, 7-seg digits.
// Optional SCOREBOARD_BLINK_EN blinks the winner's digit once the match is over.
module scoreboard #(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4,
    localparam int CW         = $clog2(HOLD_CYCLES + 1)
) (
    input  logic         clk,
    input  logic         reset,
    scoreboard_if.slave  sb
);
    typedef enum logic [1:0] {
        PLAY,
        HOLD,
        ROUND_RST,
        MATCH_OVER
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    MAX  = 3'(MAX_SCORE);

    state_t        state, state_n;
    logic [2:0]    score_l, score_l_n;
    logic [2:0]    score_r, score_r_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          win_l_q, win_r_q;
    logic          edge_l, edge_r;

    function automatic logic [6:0] seg7(input logic [2:0] v);
        logic [6:0] s;
        case (v)
            3'd0:    s = 7'b1000000;
            3'd1:    s = 7'b1111001;
            3'd2:    s = 7'b0100100;
            3'd3:    s = 7'b0110000;
            3'd4:    s = 7'b0011001;
            3'd5:    s = 7'b0010010;
            3'd6:    s = 7'b0000010;
            default: s = 7'b1111000;
        endcase
        return s;
    endfunction

    assign edge_l = sb.win_l & ~win_l_q;
    assign edge_r = sb.win_r & ~win_r_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PLAY;
            score_l <= 3'd0;
            score_r <= 3'd0;
            cnt     <= '0;
            win_l_q <= 1'b0;
            win_r_q <= 1'b0;
        end else begin
            state   <= state_n;
            score_l <= score_l_n;
            score_r <= score_r_n;
            cnt     <= cnt_n;
            win_l_q <= sb.win_l;
            win_r_q <= sb.win_r;
        end
    end

    always_comb begin
        state_n   = state;
        score_l_n = score_l;
        score_r_n = score_r;
        cnt_n     = cnt;
        case (state)
            PLAY: begin
                // Simultaneous edges replay the round without scoring
                if (edge_l || edge_r) begin
                    state_n = HOLD;
                    if (edge_l && !edge_r && score_l != MAX)
                        score_l_n = score_l + 3'd1;
                    if (edge_r && !edge_l && score_r != MAX)
                        score_r_n = score_r + 3'd1;
                end
            end
            HOLD: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    if (score_l == MAX || score_r == MAX)
                        state_n = MATCH_OVER;
                    else
                        state_n = ROUND_RST;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ROUND_RST: state_n = PLAY;
            default:   state_n = MATCH_OVER;
        endcase
    end

`ifdef SCOREBOARD_BLINK_EN
    logic [24:0] blink;
    logic        blank;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            blink <= '0;
        else
            blink <= blink + 25'd1;
    end

    assign blank = (state == MATCH_OVER) && blink[24];

    always_comb begin
        sb.hex_l = seg7(score_l);
        sb.hex_r = seg7(score_r);
        if (blank && score_l == MAX)
            sb.hex_l = 7'b1111111;
        if (blank && score_r == MAX)
            sb.hex_r = 7'b1111111;
    end
`else
    always_comb begin
        sb.hex_l = seg7(score_l);
        sb.hex_r = seg7(score_r);
    end
`endif

    assign sb.score_l     = score_l;
    assign sb.score_r     = score_r;
    assign sb.round_reset = (state == ROUND_RST) || (state == MATCH_OVER);
    assign sb.match_over  = (state == MATCH_OVER);
endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for scoreboard (MAX_SCORE=7, HOLD_CYCLES=4).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_scoreboard;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total;

    scoreboard_if sb_if ();

    scoreboard #(
        .MAX_SCORE   (7),
        .HOLD_CYCLES (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        sb_if.win_l = 1'b0;
        sb_if.win_r = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int got, input int want);
        total++;
        if (got !== want)
            $display("FAIL %s got %0d want %0d", name, got, want);
        else
            pass_cnt++;
    endtask

    // Pulse one win input for one cycle and wait until PLAY again.
    task automatic pulse(input logic left);
        if (left) sb_if.win_l = 1'b1;
        else      sb_if.win_r = 1'b1;
        @(negedge clk);
        sb_if.win_l = 1'b0;
        sb_if.win_r = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (sb_if.score_l !== 3'd0 || sb_if.score_r !== 3'd0)
            $display("FAIL reset_scores got %0d/%0d want 0/0",
                     sb_if.score_l, sb_if.score_r);
        else pass_cnt++;
        total++;
        if (sb_if.hex_l !== 7'b1000000 || sb_if.hex_r !== 7'b1000000)
            $display("FAIL reset_hex got %b/%b want 1000000/1000000",
                     sb_if.hex_l, sb_if.hex_r);
        else pass_cnt++;
        total++;
        if (sb_if.round_reset !== 1'b0 || sb_if.match_over !== 1'b0)
            $display("FAIL reset_ctrl got rr=%b mo=%b want 0/0",
                     sb_if.round_reset, sb_if.match_over);
        else pass_cnt++;
    endtask

    task automatic test_single_win();
        int high_cnt;
        int high_at;
        do_reset();
        sb_if.win_l = 1'b1;
        @(negedge clk);
        sb_if.win_l = 1'b0;
        total++;
        if (sb_if.score_l !== 3'd1)
            $display("FAIL win_score_l got %0d want 1", sb_if.score_l);
        else pass_cnt++;
        total++;
        if (sb_if.hex_l !== 7'b1111001)
            $display("FAIL win_hex_l got %b want 1111001", sb_if.hex_l);
        else pass_cnt++;
        high_cnt = 0;
        high_at  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sb_if.round_reset === 1'b1) begin
                high_cnt++;
                high_at = k;
            end
        end
        chk("win_rr_count", high_cnt, 1);
        chk("win_rr_cycle", high_at, 4);
        chk("win_score_r", int'(sb_if.score_r), 0);
    endtask

    task automatic test_held_level();
        int high_cnt;
        do_reset();
        high_cnt = 0;
        sb_if.win_r = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (sb_if.round_reset === 1'b1) high_cnt++;
        end
        chk("held_score_r", int'(sb_if.score_r), 1);
        chk("held_score_l", int'(sb_if.score_l), 0);
        chk("held_rr_count", high_cnt, 1);
        chk("held_hex_r", int'(sb_if.hex_r), int'(7'b1111001));
        sb_if.win_r = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_tie();
        int high_cnt;
        int high_at;
        do_reset();
        sb_if.win_l = 1'b1;
        sb_if.win_r = 1'b1;
        @(negedge clk);
        sb_if.win_l = 1'b0;
        sb_if.win_r = 1'b0;
        chk("tie_score_l", int'(sb_if.score_l), 0);
        chk("tie_score_r", int'(sb_if.score_r), 0);
        high_cnt = 0;
        high_at  = 0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (sb_if.round_reset === 1'b1) begin
                high_cnt++;
                high_at = k;
            end
        end
        chk("tie_rr_count", high_cnt, 1);
        chk("tie_rr_cycle", high_at, 4);
    endtask

    task automatic test_match();
        do_reset();
        for (int i = 1; i <= 7; i++) begin
            pulse(1'b1);
            chk($sformatf("match_score_l_%0d", i), int'(sb_if.score_l), i);
        end
        chk("match_hex_l", int'(sb_if.hex_l), int'(7'b1111000));
        chk("match_over", int'(sb_if.match_over), 1);
        chk("match_rr", int'(sb_if.round_reset), 1);
        pulse(1'b0);
        pulse(1'b0);
        chk("match_frozen_r", int'(sb_if.score_r), 0);
        chk("match_frozen_l", int'(sb_if.score_l), 7);
        chk("match_still_over", int'(sb_if.match_over), 1);
        repeat (5) @(negedge clk);
        chk("match_rr_held", int'(sb_if.round_reset), 1);
        do_reset();
        chk("match_clr_l", int'(sb_if.score_l), 0);
        chk("match_clr_mo", int'(sb_if.match_over), 0);
        chk("match_clr_rr", int'(sb_if.round_reset), 0);
        chk("match_clr_hex", int'(sb_if.hex_l), int'(7'b1000000));
    endtask

    task automatic test_async_reset();
        do_reset();
        sb_if.win_l = 1'b1;
        @(negedge clk);
        sb_if.win_l = 1'b0;
        @(negedge clk);
        chk("async_pre_score", int'(sb_if.score_l), 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_score_l", int'(sb_if.score_l), 0);
        chk("async_hex_l", int'(sb_if.hex_l), int'(7'b1000000));
        chk("async_rr", int'(sb_if.round_reset), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("async_still_0", int'(sb_if.score_l), 0);
        repeat (8) @(negedge clk);
        chk("async_no_rr", int'(sb_if.round_reset), 0);
        sb_if.win_l = 1'b1;
        @(negedge clk);
        sb_if.win_l = 1'b0;
        chk("async_next_win", int'(sb_if.score_l), 1);
        repeat (6) @(negedge clk);
    endtask

    initial begin
        pass_cnt = 0;
        total    = 0;
        reset    = 1'b1;
        sb_if.win_l = 1'b0;
        sb_if.win_r = 1'b0;
        test_reset();
        test_single_win();
        test_held_level();
        test_tie();
        test_match();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
